// File: rtl/cache_seq.sv
// Control sequencer for a direct-mapped, write-through cache with 4-longword lines.
// Drives external tag and data RAMs and a longword-wide memory bus; outputs are decoded from state.
module cache_seq #(
  parameter int IDX_BITS = 10,
  localparam int TAGW = 24 - IDX_BITS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req,
  input  logic                wr,
  input  logic                cache_cs,
  input  logic [25:0]         ca,
  input  logic                flush,
  output logic                ack,
  output logic [IDX_BITS-1:0] tag_addr,
  input  logic [TAGW:0]       tag_rd,
  output logic                tag_we,
  output logic [TAGW:0]       tag_wd,
  output logic [IDX_BITS+1:0] data_addr,
  output logic                data_we,
  output logic                data_src,
  output logic                bus_req,
  output logic                bus_wr,
  output logic [25:0]         bus_addr,
  input  logic                bus_ack,
  output logic                busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_COMPARE,
    S_FILL,
    S_WTHRU,
    S_BYPASS,
    S_FLUSH
  } state_t;

  state_t              state, state_nxt;
  logic [25:0]         ca_q;
  logic                wr_q;
  logic                hit_q;
  logic [1:0]          beat;
  logic [IDX_BITS-1:0] flush_cnt;
  logic                flush_pend;

  // Fields of the captured longword address: {tag, index, word}.
  logic [TAGW-1:0]     tag;
  logic [IDX_BITS-1:0] idx;
  logic [1:0]          word;
  logic [1:0]          fill_word;
  logic                hit;
  logic                accept;

  assign word      = ca_q[1:0];
  assign idx       = ca_q[IDX_BITS+1:2];
  assign tag       = ca_q[25:IDX_BITS+2];
  assign fill_word = word + beat;  // wraps 3->0 inside the line
  assign hit       = tag_rd[TAGW] && (tag_rd[TAGW-1:0] == tag);

  // A pending or fresh flush always wins over a request waiting in IDLE.
  assign accept = (state == S_IDLE) && !flush && !flush_pend && req;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; the decode below uses blocking assignments in always_comb.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      ca_q       <= '0;
      wr_q       <= 1'b0;
      hit_q      <= 1'b0;
      beat       <= '0;
      flush_cnt  <= '0;
      flush_pend <= 1'b0;
    end else begin
      state <= state_nxt;

      if (accept) begin
        ca_q <= ca;
        wr_q <= wr;
      end

      if (state == S_COMPARE) hit_q <= hit;

      if (state == S_FILL) begin
        if (bus_ack) beat <= beat + 2'd1;
      end else begin
        beat <= '0;
      end

      if (state == S_FLUSH) flush_cnt <= flush_cnt + IDX_BITS'(1);
      else                  flush_cnt <= '0;

      // Pulses seen while busy collapse into one flush taken on the next IDLE.
      if (state != S_IDLE && flush) flush_pend <= 1'b1;
      else if (state == S_IDLE)     flush_pend <= 1'b0;
    end
  end

  // NOTE: every output and state_nxt gets a default before the case, so no
  // path through the decode leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    ack       = 1'b0;
    tag_addr  = '0;
    tag_we    = 1'b0;
    tag_wd    = '0;
    data_addr = '0;
    data_we   = 1'b0;
    data_src  = 1'b0;
    bus_req   = 1'b0;
    bus_wr    = 1'b0;
    bus_addr  = '0;

    unique case (state)
      S_IDLE: begin
        if (flush || flush_pend) state_nxt = S_FLUSH;
        else if (req)            state_nxt = cache_cs ? S_LOOKUP : S_BYPASS;
      end

      S_LOOKUP: begin
        tag_addr  = idx;
        state_nxt = S_COMPARE;
      end

      S_COMPARE: begin
        if (wr_q) begin
          state_nxt = S_WTHRU;
        end else if (hit) begin
          ack       = 1'b1;
          data_addr = {idx, word};
          state_nxt = S_IDLE;
        end else begin
          state_nxt = S_FILL;
        end
      end

      // Critical word first; the tag is only validated with the last beat.
      S_FILL: begin
        bus_req   = 1'b1;
        bus_addr  = {tag, idx, fill_word};
        data_addr = {idx, fill_word};
        tag_addr  = idx;
        if (bus_ack) begin
          data_we = 1'b1;
          ack     = (beat == 2'd0);
          if (beat == 2'd3) begin
            tag_we    = 1'b1;
            tag_wd    = {1'b1, tag};
            state_nxt = S_IDLE;
          end
        end
      end

      // Write-through without allocation: only a hit updates the data RAM.
      S_WTHRU: begin
        bus_req   = 1'b1;
        bus_wr    = 1'b1;
        bus_addr  = ca_q;
        data_addr = {idx, word};
        data_src  = 1'b1;
        if (bus_ack) begin
          ack       = 1'b1;
          data_we   = hit_q;
          state_nxt = S_IDLE;
        end
      end

      S_BYPASS: begin
        bus_req  = 1'b1;
        bus_wr   = wr_q;
        bus_addr = ca_q;
        if (bus_ack) begin
          ack       = 1'b1;
          state_nxt = S_IDLE;
        end
      end

      // NOTE: the tag RAM has no reset of its own; invalidation happens only
      // through this sweep, one line per cycle.
      S_FLUSH: begin
        tag_addr = flush_cnt;
        tag_we   = 1'b1;
        if (flush_cnt == {IDX_BITS{1'b1}}) state_nxt = S_IDLE;
      end

      default: state_nxt = S_IDLE;
    endcase
  end

  assign busy = (state != S_IDLE);

  a_ack_single_cycle: assert property (@(posedge clk) disable iff (rst) ack |=> !ack);
  a_tag_only_full_line: assert property (@(posedge clk) disable iff (rst)
    (tag_we && state == S_FILL) |-> (beat == 2'd3));

endmodule

// File: tb/tb_cache_seq.sv
// Directed bench for cache_seq: tag RAM and bus models, expected events queued by the
// stimulus and compared by a monitor whenever the DUT strobes ack, a RAM write or a bus beat.
module tb_cache_seq;

  localparam int IDX_BITS = 10;
  localparam int TAGW     = 24 - IDX_BITS;
  localparam int LINES    = 1 << IDX_BITS;

  logic                clk = 1'b0;
  logic                rst, req, wr, cache_cs, flush;
  logic [25:0]         ca;
  logic                ack, tag_we, data_we, data_src, bus_req, bus_wr, bus_ack, busy;
  logic [IDX_BITS-1:0] tag_addr;
  logic [TAGW:0]       tag_rd, tag_wd;
  logic [IDX_BITS+1:0] data_addr;
  logic [25:0]         bus_addr;

  always #5 clk = ~clk;

  cache_seq #(.IDX_BITS(IDX_BITS)) dut (
    .clk(clk), .rst(rst), .req(req), .wr(wr), .cache_cs(cache_cs), .ca(ca),
    .flush(flush), .ack(ack), .tag_addr(tag_addr), .tag_rd(tag_rd),
    .tag_we(tag_we), .tag_wd(tag_wd), .data_addr(data_addr), .data_we(data_we),
    .data_src(data_src), .bus_req(bus_req), .bus_wr(bus_wr), .bus_addr(bus_addr),
    .bus_ack(bus_ack), .busy(busy)
  );

  // Tag RAM: one-cycle read latency. Power-up contents are valid lines with
  // tag 0, so a missing or broken flush shows up as false hits.
  logic [TAGW:0] tag_mem [LINES];
  logic          mem_ready = 1'b0;
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < LINES; i++) tag_mem[i] <= {1'b1, {TAGW{1'b0}}};
      mem_ready <= 1'b1;
    end else if (tag_we) begin
      tag_mem[tag_addr] <= tag_wd;
    end
    tag_rd <= tag_mem[tag_addr];
  end

  // Bus: grants two cycles out of three; hold_bus withholds grants from the next edge on.
  int unsigned cyc      = 0;
  logic        gnt_q    = 1'b0;
  logic        hold_bus = 1'b0;
  always @(posedge clk) begin
    cyc   <= cyc + 1;
    gnt_q <= !hold_bus && (cyc % 3 != 2);
  end
  assign bus_ack = bus_req && gnt_q;

  typedef struct packed {
    logic                ack;
    logic                beat;
    logic                bus_wr;
    logic [25:0]         bus_addr;
    logic                data_we;
    logic [IDX_BITS+1:0] data_addr;
    logic                data_src;
    logic                tag_we;
    logic [IDX_BITS-1:0] tag_addr;
    logic [TAGW:0]       tag_wd;
  } ev_t;

  ev_t exp_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;
  int  beats    = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req_v);
    n_checks++;
    if (act !== req_v) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h, required 0x%0h (t=%0t)", name, act, req_v, $time);
    end
  endtask

  // Fields that carry no meaning for an event are cleared before comparing.
  function automatic ev_t norm(input ev_t e);
    ev_t r = e;
    if (!r.beat) begin r.bus_wr = 1'b0; r.bus_addr = '0; end
    if (!r.data_we) begin
      r.data_src = 1'b0;
      if (!(r.ack && !r.beat)) r.data_addr = '0;
    end
    if (!r.tag_we) begin r.tag_addr = '0; r.tag_wd = '0; end
    return r;
  endfunction

  function automatic logic [127:0] outs();
    return 128'({ack, busy, bus_req, bus_wr, tag_we, data_we, data_src,
                 tag_addr, tag_wd, data_addr, bus_addr});
  endfunction

  task automatic push_ev(input logic a, input logic bt, input logic bw, input logic [25:0] ba,
                         input logic dwe, input logic [IDX_BITS+1:0] da, input logic ds,
                         input logic twe, input logic [IDX_BITS-1:0] ta, input logic [TAGW:0] twd);
    ev_t e;
    e.ack = a; e.beat = bt; e.bus_wr = bw; e.bus_addr = ba;
    e.data_we = dwe; e.data_addr = da; e.data_src = ds;
    e.tag_we = twe; e.tag_addr = ta; e.tag_wd = twd;
    exp_q.push_back(e);
  endtask

  task automatic fill_beat(input logic a, input logic [25:0] ba, input logic [IDX_BITS+1:0] da);
    push_ev(a, 1'b1, 1'b0, ba, 1'b1, da, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic fill_last(input logic [25:0] ba, input logic [IDX_BITS+1:0] da,
                           input logic [IDX_BITS-1:0] ta, input logic [TAGW:0] twd);
    push_ev(1'b0, 1'b1, 1'b0, ba, 1'b1, da, 1'b0, 1'b1, ta, twd);
  endtask

  task automatic push_flush();
    for (int i = 0; i < LINES; i++)
      push_ev(1'b0, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b1, IDX_BITS'(i), '0);
  endtask

  task automatic monitor();
    ev_t obs, e;
    forever begin
      @(negedge clk);
      if (ack || tag_we || data_we || (bus_req && bus_ack)) begin
        obs = '0;
        obs.ack = ack; obs.beat = bus_req && bus_ack; obs.bus_wr = bus_wr;
        obs.bus_addr = bus_addr; obs.data_we = data_we; obs.data_addr = data_addr;
        obs.data_src = data_src; obs.tag_we = tag_we; obs.tag_addr = tag_addr;
        obs.tag_wd = tag_wd;
        if (obs.beat) beats++;
        if (exp_q.size() == 0) begin
          check("unexpected_event", 128'(norm(obs)), 128'(0));
        end else begin
          e = exp_q.pop_front();
          check("event", 128'(norm(obs)), 128'(norm(e)));
        end
      end
    end
  endtask

  // lat counts falling edges from driving req to seeing ack.
  task automatic do_req(input logic [25:0] a, input logic w, input logic cs, output int lat);
    @(posedge clk); #1;
    ca = a; wr = w; cache_cs = cs; req = 1'b1;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!ack && lat < 3000);
    check("ack_seen", 128'(ack), 128'(1));
    @(posedge clk); #1;
    req = 1'b0; wr = 1'b0; cache_cs = 1'b0; ca = '0;
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin @(negedge clk); n++; end while (busy && n < 3000);
    check("back_to_idle", 128'(busy), 128'(0));
  endtask

  task automatic run_tests();
    int lat, cnt, b0;
    rst = 1'b1; req = 1'b0; wr = 1'b0; cache_cs = 1'b0; ca = '0; flush = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", outs(), 128'(0));
    @(posedge clk); #1 rst = 1'b0;
    repeat (4) begin @(negedge clk); check("no_auto_flush", 128'(busy), 128'(0)); end

    // Flush: 2^IDX_BITS cycles, one tag clear per cycle.
    push_flush();
    @(posedge clk); #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    cnt = 0;
    do begin @(negedge clk); if (busy) cnt++; end while (busy && cnt < 2000);
    check("flush_cycles", 128'(cnt), 128'(LINES));

    // Read miss ca=0x10 (index 4, word 0): beats 0x10..0x13, tag {1,0} at index 4.
    fill_beat(1'b1, 26'h0000010, 12'h010);
    fill_beat(1'b0, 26'h0000011, 12'h011);
    fill_beat(1'b0, 26'h0000012, 12'h012);
    fill_last(26'h0000013, 12'h013, 10'd4, 15'h4000);
    do_req(26'h0000010, 1'b0, 1'b1, lat);
    wait_idle();

    // Read hit ca=0x13: accepted on the next rising edge, ack two cycles later.
    push_ev(1'b1, 1'b0, 1'b0, '0, 1'b0, 12'h013, 1'b0, 1'b0, '0, '0);
    do_req(26'h0000013, 1'b0, 1'b1, lat);
    check("hit_latency", 128'(lat), 128'(3));
    wait_idle();

    // Read miss ca=0x17 (index 5, word 3): critical word first, then wrap.
    fill_beat(1'b1, 26'h0000017, 12'h017);
    fill_beat(1'b0, 26'h0000014, 12'h014);
    fill_beat(1'b0, 26'h0000015, 12'h015);
    fill_last(26'h0000016, 12'h016, 10'd5, 15'h4000);
    do_req(26'h0000017, 1'b0, 1'b1, lat);
    wait_idle();

    // Write hit ca=0x11: bus write plus data write of CPU data at {4,1}.
    push_ev(1'b1, 1'b1, 1'b1, 26'h0000011, 1'b1, 12'h011, 1'b1, 1'b0, '0, '0);
    do_req(26'h0000011, 1'b1, 1'b1, lat);
    wait_idle();

    // Write miss ca=0x0400011 (tag 0x400): bus write only, no allocation.
    push_ev(1'b1, 1'b1, 1'b1, 26'h0400011, 1'b0, '0, 1'b0, 1'b0, '0, '0);
    do_req(26'h0400011, 1'b1, 1'b1, lat);
    wait_idle();
    push_ev(1'b1, 1'b0, 1'b0, '0, 1'b0, 12'h011, 1'b0, 1'b0, '0, '0);
    do_req(26'h0000011, 1'b0, 1'b1, lat);
    check("hit_after_write_miss", 128'(lat), 128'(3));
    wait_idle();

    // Uncached read with a flush pulse while it waits for the bus; the flush
    // runs next, then the following read (line now invalid) misses.
    push_ev(1'b1, 1'b1, 1'b0, 26'h3ABCDEF, 1'b0, '0, 1'b0, 1'b0, '0, '0);
    push_flush();
    fill_beat(1'b1, 26'h0000013, 12'h013);
    fill_beat(1'b0, 26'h0000010, 12'h010);
    fill_beat(1'b0, 26'h0000011, 12'h011);
    fill_last(26'h0000012, 12'h012, 10'd4, 15'h4000);
    hold_bus = 1'b1;
    @(posedge clk);
    fork
      do_req(26'h3ABCDEF, 1'b0, 1'b0, lat);
      begin
        @(posedge clk); @(posedge clk); #1 flush = 1'b1;
        @(negedge clk);
        check("bypass_waits_on_bus", 128'({busy, bus_req}), 128'(3));
        @(posedge clk); #1 flush = 1'b0; hold_bus = 1'b0;
      end
    join
    do_req(26'h0000013, 1'b0, 1'b1, lat);
    wait_idle();

    // Uncached write.
    push_ev(1'b1, 1'b1, 1'b1, 26'h1234567, 1'b0, '0, 1'b0, 1'b0, '0, '0);
    do_req(26'h1234567, 1'b1, 1'b0, lat);
    wait_idle();

    // Reset after beat 2 of a fill at ca=0x20 (index 8): no tag write, outputs cleared.
    fill_beat(1'b1, 26'h0000020, 12'h020);
    fill_beat(1'b0, 26'h0000021, 12'h021);
    fill_beat(1'b0, 26'h0000022, 12'h022);
    b0 = beats;
    do_req(26'h0000020, 1'b0, 1'b1, lat);
    cnt = 0;
    while (beats < b0 + 3 && cnt < 200) begin @(negedge clk); #1; cnt++; end
    check("fill_reached_beat2", 128'(beats - b0), 128'(3));
    hold_bus = 1'b1;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst_mid_fill_outputs", outs(), 128'(0));
    @(posedge clk); #1 rst = 1'b0; hold_bus = 1'b0;

    fill_beat(1'b1, 26'h0000020, 12'h020);
    fill_beat(1'b0, 26'h0000021, 12'h021);
    fill_beat(1'b0, 26'h0000022, 12'h022);
    fill_last(26'h0000023, 12'h023, 10'd8, 15'h4000);
    do_req(26'h0000020, 1'b0, 1'b1, lat);
    wait_idle();
    push_ev(1'b1, 1'b0, 1'b0, '0, 1'b0, 12'h022, 1'b0, 1'b0, '0, '0);
    do_req(26'h0000022, 1'b0, 1'b1, lat);
    check("hit_after_refill", 128'(lat), 128'(3));
    wait_idle();

    repeat (5) @(negedge clk);
    check("scoreboard_drained", 128'(exp_q.size()), 128'(0));
  endtask

  initial begin
    fork
      monitor();
      run_tests();
    join_any
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit reached");
  end

endmodule
